// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding selects and load-use interlock.
//   CLK/nRST              clock, async active-low reset
//   en, flush             pipeline advance strobe, squash of the ID instruction
//   id_*                  register usage of the instruction currently in ID
//   forwarda/forwardb     registered ALU operand selects for the EX instruction
//   hazard_stall          combinational interlock request (IF/ID hold, bubble to EX)
//   FORWARDING_EN         when defined, forwarding is enabled; otherwise selects
//                         are tied to 000 and every RAW dependency interlocks
module fwd_hazard_unit (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       en,
    input  logic       flush,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic [4:0] id_wsel,
    input  logic       id_regwen,
    input  logic       id_memread,
    input  logic       id_lui,
    output logic [2:0] forwarda,
    output logic [2:0] forwardb,
    output logic       hazard_stall
);
    typedef struct packed {
        logic [4:0] wsel;
        logic       regwen;
        logic       memread;
        logic       lui;
    } shadow_t;

    shadow_t sh_idex_q, sh_idex_d, sh_exmem_q, sh_exmem_d, id_sh;

    function automatic logic raw(input shadow_t s, input logic [4:0] r, input logic used);
        return used && r != 5'd0 && s.regwen && s.wsel == r;
    endfunction

    assign id_sh = '{wsel: id_wsel, regwen: id_regwen, memread: id_memread, lui: id_lui};

`ifdef FORWARDING_EN
    logic [2:0] forwarda_q, forwarda_d, forwardb_q, forwardb_d;

    // The younger producer (sh_idex) shadows the older one (sh_exmem).
    function automatic logic [2:0] sel(input shadow_t yi, input shadow_t ol,
                                       input logic [4:0] r, input logic used);
        return (raw(yi, r, used) && !yi.memread) ? (yi.lui ? 3'b011 : 3'b001) :
               (raw(ol, r, used) && !ol.memread) ? (ol.lui ? 3'b100 : 3'b010) : 3'b000;
    endfunction

    // Only loads interlock; everything else is forwarded.
    always_comb begin
        hazard_stall = ((raw(sh_idex_q, id_rs, id_rs_used) || raw(sh_idex_q, id_rt, id_rt_used)) && sh_idex_q.memread) ||
                       ((raw(sh_exmem_q, id_rs, id_rs_used) || raw(sh_exmem_q, id_rt, id_rt_used)) && sh_exmem_q.memread);
        forwarda_d   = !en ? forwarda_q : (flush || hazard_stall) ? 3'b000 : sel(sh_idex_q, sh_exmem_q, id_rs, id_rs_used);
        forwardb_d   = !en ? forwardb_q : (flush || hazard_stall) ? 3'b000 : sel(sh_idex_q, sh_exmem_q, id_rt, id_rt_used);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            forwarda_q <= 3'b000;
            forwardb_q <= 3'b000;
        end else begin
            forwarda_q <= forwarda_d;
            forwardb_q <= forwardb_d;
        end
    end

    assign forwarda = forwarda_q;
    assign forwardb = forwardb_q;
`else
    logic unused_exmem_fields;

    // Pure interlock: any in-flight producer of a source register stalls ID.
    always_comb begin
        hazard_stall = raw(sh_idex_q, id_rs, id_rs_used) || raw(sh_idex_q, id_rt, id_rt_used) ||
                       raw(sh_exmem_q, id_rs, id_rs_used) || raw(sh_exmem_q, id_rt, id_rt_used);
    end

    assign unused_exmem_fields = ^{sh_exmem_q.memread, sh_exmem_q.lui};
    assign forwarda = 3'b000;
    assign forwardb = 3'b000;
`endif

    always_comb begin
        sh_exmem_d = en ? sh_idex_q : sh_exmem_q;
        sh_idex_d  = !en ? sh_idex_q : (flush || hazard_stall) ? shadow_t'('0) : id_sh;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sh_idex_q  <= '0;
            sh_exmem_q <= '0;
        end else begin
            sh_idex_q  <= sh_idex_d;
            sh_exmem_q <= sh_exmem_d;
        end
    end
endmodule
